multdiv_iter: RTL and testbench
===============================

Name: multdiv_iter

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage, beside the ALU and arithmetic barrel shifter.
- It consumes the same operand buses and uses shift steps internally: a radix-2 shift-add multiplier and a restoring divider.
- Its result is multiplexed into the writeback path. The pipeline stalls on busy.

Parameters:
WIDTH, 32, operand and result width in bits
ITER, 32, iteration cycles per operation (equals WIDTH)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
data_operandA  in  WIDTH  multiplicand / dividend (signed)
data_operandB  in  WIDTH  multiplier / divisor (signed)
ctrl_MULT  in  1  single-cycle start pulse for multiply
ctrl_DIV  in  1  single-cycle start pulse for divide
data_result  out  WIDTH  product low word or quotient
data_exception  out  1  overflow or divide-by-zero flag, valid with data_resultRDY
data_resultRDY  out  1  one-cycle pulse: result valid
busy  out  1  high while an operation is in flight

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0. data_result=0, data_exception=0, data_resultRDY=0, busy=0. Reset mid-operation aborts the operation; no RDY pulse follows.
- States: IDLE, MUL, DIV, DONE.
- Start:
  - ctrl_MULT or ctrl_DIV is sampled on a rising edge (edge S) in any state.
  - Operands are latched at S. Counter is cleared. Next state is MUL or DIV. busy goes to 1 from S.
- Simultaneous ctrl_MULT and ctrl_DIV: multiply wins.
- Start while busy: the in-flight operation is abandoned, the new one restarts at that edge, and no RDY pulse is issued for the abandoned operation.
- Iteration:
  - One step per edge, for ITER edges (S+1..S+ITER).
  - At edge S+ITER the state goes to DONE.
  - data_resultRDY=1, data_result and data_exception are updated, and busy=0.
  - RDY is therefore high during the cycle after edge S+32. Latency is 32 edges.
- DONE: lasts one cycle, then IDLE. data_resultRDY returns to 0.
- data_result and data_exception hold their values until the next completion or reset.
- Multiply:
  - Signed product formed by shift-add on magnitudes, with the sign applied at the end (or Booth).
  - data_result = low 32 bits of the 64-bit product.
  - data_exception=1 iff the product does not fit in signed 32 bits (upper 33 bits of the product are not all equal).
- Divide:
  - Signed, quotient truncated toward zero. Restoring divide on magnitudes; quotient negated if operand signs differ. Remainder is discarded.
  - Divisor 0: data_result=0, data_exception=1, full latency still applies.
  - 0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
- Operand inputs may change after S without affecting the operation.
- ctrl held high for several cycles: each sampled high edge restarts the operation. Drivers must pulse ctrl for one cycle.

Test Plan:
1. reset high with random inputs, then low -> all outputs 0; no RDY pulse appears in the next 40 cycles.
2. MULT with A=7, B=-3 -> after 32 edges: RDY one cycle, result=0xFFFFFFEB (-21), exception=0; busy high for exactly the 32 intervening cycles.
3. MULT with A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. MULT with A=-1, B=0x80000000 -> result=0x80000000, exception=1.
4. DIV with A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0. DIV with A=100, B=0 -> result=0, exception=1. DIV with A=0x80000000, B=-1 -> result=0x80000000, exception=1.
5. DIV with A=50, B=5 started, then MULT with A=6, B=9 issued 10 cycles later -> exactly one RDY pulse, 32 edges after the MULT, result=54. Both ctrls in the same cycle -> multiply result.
6. reset asserted asynchronously at iteration 15 -> outputs clear immediately with no clock edge; no RDY pulse. A subsequent MULT with A=3, B=4 gives result=12 with normal latency.

Source files
------------

// File: rtl/multdiv_iter_if.sv
// Operand, control and result bundle between the execute stage and the
// iterative multiply/divide unit.
interface multdiv_iter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 shift-add) and divide (restoring) unit.
// Both operate on operand magnitudes; the sign is applied on completion.
module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input logic           clock,
  input logic           reset,
  multdiv_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam int CW = $clog2(ITER + 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic               start;
  logic               last_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_ovf;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   div_quot;
  logic               div_ovf;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign last_step = (count_q == CW'(ITER - 1));
  assign a_mag     = magnitude(bus.data_operandA);
  assign b_mag     = magnitude(bus.data_operandB);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  // A start pulse overrides whatever is in flight; multiply has priority.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = bus.ctrl_MULT ? MUL : DIV;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        MUL:     if (last_step) state_d = DONE;
        DIV:     if (last_step) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    mul_prod = neg_q ? (~mul_next + 1'b1) : mul_next;
    mul_ovf  = ~((&mul_prod[2*WIDTH-1:WIDTH-1]) | ~(|mul_prod[2*WIDTH-1:WIDTH-1]));

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    div_quot  = neg_q ? (~div_next[WIDTH-1:0] + 1'b1) : div_next[WIDTH-1:0];
    div_ovf   = ~neg_q & div_next[WIDTH-1];
  end

  always_comb begin
    count_d  = count_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;
    if (start) begin
      count_d = '0;
      busy_d  = 1'b1;
      neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      dz_d    = ~bus.ctrl_MULT & (bus.data_operandB == '0);
      if (bus.ctrl_MULT) begin
        opnd_d = a_mag;
        acc_d  = {{WIDTH{1'b0}}, b_mag};
      end else begin
        opnd_d = b_mag;
        acc_d  = {{WIDTH{1'b0}}, a_mag};
      end
    end else begin
      case (state_q)
        MUL: begin
          acc_d   = mul_next;
          count_d = count_q + 1'b1;
          if (last_step) begin
            count_d  = '0;
            result_d = mul_prod[WIDTH-1:0];
            exc_d    = mul_ovf;
            rdy_d    = 1'b1;
            busy_d   = 1'b0;
          end
        end
        DIV: begin
          acc_d   = div_next;
          count_d = count_q + 1'b1;
          if (last_step) begin
            count_d  = '0;
            result_d = dz_q ? '0 : div_quot;
            exc_d    = dz_q | div_ovf;
            rdy_d    = 1'b1;
            busy_d   = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bus.data_result    = result_q;
    bus.data_exception = exc_q;
    bus.data_resultRDY = rdy_q;
    bus.busy           = busy_q;
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter: stimulus pushes expected results,
// a negedge monitor pops and compares on every RDY pulse.
module tb_multdiv_iter;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total_checks = 0;
  int   pass_checks  = 0;
  exp_t exp_q[$];

  multdiv_iter_if #(.WIDTH(32)) bus ();

  multdiv_iter #(.WIDTH(32), .ITER(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual === expected) pass_checks++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Issue one start pulse; the sampling edge S is the next posedge and
  // RDY is expected during the cycle after edge S+32.
  task automatic applyStimulus(input logic mul, input logic div,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input logic exp_exc);
    exp_t e;
    @(posedge clock);
    #1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = mul;
    bus.ctrl_DIV      = div;
    e.res = exp_res;
    e.exc = exp_exc;
    e.cyc = cyc + 1 + 32;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain", exp_q.size(), 32'd0);
  endtask

  always @(negedge clock) begin
    if (!reset && bus.data_resultRDY) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("result", bus.data_result, e.res);
        checkOutput("exception", {31'd0, bus.data_exception}, {31'd0, e.exc});
        checkOutput("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    int busy_cnt;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    repeat (4) begin
      @(posedge clock);
      #1;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      bus.ctrl_MULT     = 1'($urandom);
      bus.ctrl_DIV      = 1'($urandom);
    end
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_result", bus.data_result, 32'd0);
    checkOutput("reset_exception", {31'd0, bus.data_exception}, 32'd0);
    checkOutput("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clock);

    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    busy_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.busy) busy_cnt++;
    end
    checkOutput("busy_cycles", busy_cnt, 32'd32);
    waitIdle();

    applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0);
    waitIdle();

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    waitIdle();
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd0, 32'd0, 1'b1);
    waitIdle();
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    waitIdle();
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 1'b0);
    waitIdle();

    // Abandoned divide: only the multiply may produce a pulse.
    applyStimulus(1'b0, 1'b1, 32'd50, 32'd5, 32'd10, 1'b0);
    repeat (8) @(posedge clock);
    #1;
    exp_q.delete();
    applyStimulus(1'b1, 1'b0, 32'd6, 32'd9, 32'd54, 1'b0);
    waitIdle();
    applyStimulus(1'b1, 1'b1, 32'd5, 32'd3, 32'd15, 1'b0);
    waitIdle();

    // Asynchronous reset partway through an operation.
    applyStimulus(1'b1, 1'b0, 32'd11, 32'd13, 32'd143, 1'b0);
    repeat (14) @(posedge clock);
    exp_q.delete();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_result", bus.data_result, 32'd0);
    checkOutput("async_exception", {31'd0, bus.data_exception}, 32'd0);
    checkOutput("async_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("async_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (40) @(negedge clock);
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0);
    waitIdle();
    repeat (40) @(negedge clock);

    $display("[TB] %0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
